// File: rtl/dotprod_pkg.sv
// Shared types for the dotprod unit and the arbiter that time-shares it.
package dotprod_pkg;

  localparam int VEC_LEN = 8;
  localparam int ELEM_W  = 32;
  localparam int RES_W   = 64;

  typedef logic [VEC_LEN-1:0][ELEM_W-1:0] vec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } dp_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dotprod_arbiter.sv
// Shares one dotprod unit among NREQ requesters: round-robin grant, start/done
// sequencing, ID-tagged response and a watchdog that aborts a hung operation.
module dotprod_arbiter
  import dotprod_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  vec_t [NREQ-1:0]          req_a,
  input  vec_t [NREQ-1:0]          req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [RES_W-1:0]         rsp_result,
  output logic                     rsp_timeout,
  output vec_t                     dp_a,
  output vec_t                     dp_b,
  output logic                     dp_start,
  input  logic                     dp_done,
  input  logic [RES_W-1:0]         dp_result,
  output logic                     dp_rst,
  output dp_arb_state_t            dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req_* and rsp_* follow this rule, and requesters hold operands
  // stable while valid and not yet granted.

  dp_arb_state_t   state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   wd_cnt;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  vec_t            sel_a;
  vec_t            sel_b;
  logic            take;
  logic            done_ok;
  logic            wd_expire;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    gnt_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        gnt_id = IDW'(i);
        sel_a  = req_a[i];
        sel_b  = req_b[i];
      end
    end
  end

  assign take      = (state == ST_IDLE) && (|req_valid) && !rst;
  assign req_ready = take ? grant : '0;

  // The first WAIT cycle (wd_cnt==0) may still see done from the previous op.
  assign done_ok   = (state == ST_WAIT) && (wd_cnt != '0) && dp_done;
  assign wd_expire = (state == ST_WAIT) && (wd_cnt == CNT_LAST) && !done_ok;

  // Abort pulse lands in the last WAIT cycle; the integrator ORs rst into it.
  assign dp_rst    = wd_expire && !rst;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      wd_cnt      <= '0;
      dp_a        <= '0;
      dp_b        <= '0;
      dp_start    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      dp_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            dp_a     <= sel_a;
            dp_b     <= sel_b;
            rsp_id   <= gnt_id;
            dp_start <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + CW'(1);
          if (done_ok) begin
            rsp_result  <= dp_result;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else if (wd_expire) begin
            rsp_result  <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == ID_LAST) ? '0 : rsp_id + IDW'(1);
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dotprod_arbiter.md
# dotprod_arbiter

Shares one `dotprod` unit (8×32-bit operand vectors, 64-bit result, start/done handshake) among `NREQ` requesters. Arbitration is round-robin. The block captures the winning requester's operands and sequences `dotprod` through start and done. It returns the result tagged with the requester ID, and a watchdog recovers the unit if `done` never arrives. It sits between the request ports of the client blocks and the single `dotprod` instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..16).
- `TIMEOUT`, 64: maximum cycles spent in WAIT before abort (≥4).

Ports:
- `clk`  in  1  single clock; everything on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester request. Operands must stay stable while valid and not yet granted.
- `req_a`, `req_b`  in  NREQ×`vec_t`  operand vectors per requester.
- `req_ready`  out  NREQ  one-hot grant. The handshake completes on the cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`.
- `rsp_id`  out  $clog2(NREQ)  requester index of the response.
- `rsp_result`  out  64  dot product; 0 on timeout.
- `rsp_timeout`  out  1  watchdog abort flag.
- `dp_a`, `dp_b`  out  `vec_t`  operands to `dotprod`; held stable from ISSUE through WAIT.
- `dp_start`  out  1  one-cycle start pulse.
- `dp_done`  in  1  completion level from `dotprod`.
- `dp_result`  in  64  result from `dotprod`.
- `dp_rst`  out  1  one-cycle abort reset to `dotprod` on timeout, ORed with `rst` at the top level.

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, the arbiter drives `req_ready` one-hot to the winner: the first valid index at or after `ptr`, wrapping.
  - On that edge the block latches the winner's `req_a`/`req_b` into `dp_a`/`dp_b`, stores the ID, and moves to ISSUE.
  - `req_ready` is high only in IDLE and is always 0 otherwise.
- **ISSUE**: `dp_start`=1 for exactly this cycle. The watchdog counter clears and the FSM moves to WAIT.
- **WAIT**
  - The counter increments every cycle.
  - `dp_done` is ignored in the first WAIT cycle, because `dotprod` may still show `done` from the previous operation.
  - From the second WAIT cycle, `dp_done`=1 captures `dp_result` into `rsp_result`, clears `rsp_timeout`, and moves to RESP.
  - If the counter reaches `TIMEOUT-1` without `done`, the block sets `rsp_result`=0 and `rsp_timeout`=1, pulses `dp_rst` for one cycle, and moves to RESP.
  - If `done` and the timeout occur in the same cycle, `done` wins.
- **RESP**
  - `rsp_valid`=1. `rsp_id`, `rsp_result` and `rsp_timeout` are held stable until `rsp_ready`.
  - On the handshake: `ptr` ← granted ID + 1, mod NREQ, then the FSM returns to IDLE.
- New requests are not accepted during ISSUE, WAIT or RESP, so the block has a single outstanding operation.
- A requester that drops `req_valid` before it is granted is skipped; this is legal.
- No arithmetic is done here. Results pass through as the full 64 bits.

## Timing
- Reset values: FSM IDLE, `ptr`=0, counter 0.
  - Outputs: `req_ready`=0 (forced during `rst`), `dp_start`=0, `dp_rst`=0, `dp_a`/`dp_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_timeout`=0.
- Cycle 0 is the grant edge. Then: `dp_start` in cycle 1, WAIT from cycle 2, `rsp_valid` one cycle after the first qualified `dp_done`.
  - Minimum grant-to-`rsp_valid` latency is 4 cycles, plus the latency of `dotprod`.
- The earliest next grant is the cycle after the `rsp_ready` handshake.
- Timeout: `rsp_valid` rises `TIMEOUT`+2 cycles after the grant, and `dp_rst` is high in the cycle before `rsp_valid`.
- `rst` asserted mid-operation returns every register to its reset value on the next edge.
  - Any in-flight operation and pending response are dropped, and `ptr` returns to 0.

## Structure
- Package `dotprod_pkg` holds:
  - `VEC_LEN`=8, `ELEM_W`=32, `RES_W`=64.
  - `typedef logic [VEC_LEN-1:0][ELEM_W-1:0] vec_t`.
  - The FSM state enum `dp_arb_state_t`.
- Sub-module `rr_arbiter`: parameter `NREQ`; inputs `req` and `ptr`; output one-hot `grant`. Purely combinational.
- The top level holds the FSM, operand registers, watchdog counter and response registers.

## Test plan
- Single request:
  - Stimulus: req0, a=[1..8], b=[8..1].
  - Required: `dp_start` pulses once; `rsp_valid` with `rsp_id`=0, `rsp_result`=120, `rsp_timeout`=0.
- Round-robin:
  - Stimulus: all 4 requesters hold valid with distinct vectors (requester k: a=all k+1, b=all 1).
  - Required: grant order 0,1,2,3,0. Results are 8,16,24,32, each tagged with the correct ID.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 10 cycles.
  - Required: response stays stable. `req_ready` stays 0 for all requesters even with `req_valid` high. A grant follows the cycle after the handshake.
- Timeout:
  - Stimulus: the `dotprod` model never raises `done`, `TIMEOUT`=16.
  - Required: `dp_rst` pulses exactly once; `rsp_timeout`=1, `rsp_result`=0, `rsp_valid` at grant+18. The next request completes normally.
- Stale done:
  - Stimulus: `dp_done` stuck high from the previous op through ISSUE and the first WAIT cycle, then low, then high 5 cycles later.
  - Required: the result is captured on the later `done`, not the stale one.
- Reset mid-operation:
  - Stimulus: assert `rst` during WAIT.
  - Required: all outputs are at reset values the next cycle, no `rsp_valid` appears, and `ptr` restarts so req0 wins next.
